ccc_phase_step_ctrl: RTL

- Sequencer upstream of the DDR3 PLL clock-conditioning block; drives its dynamic phase-adjust pins (PHASE_OUTx_SEL, PHASE_DIRECTION, PHASE_ROTATE, LOAD_PHASE_N).
- Accepts phase-step and phase-reload requests from DDR training logic over a valid/ready handshake and emits correctly timed rotate/load pulses.
- Tracks the phase position of OUT0, OUT2 and OUT3.
- Qualifies PLL lock and aborts any operation that is in flight when lock is lost.

---
 rtl/ccc_phase_step_ctrl.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ccc_phase_step_ctrl.sv
// rtl/ccc_phase_step_ctrl.sv - DDR3 PLL dynamic phase-adjust sequencer
//
// Takes phase-step / phase-reload requests from DDR training over a
// valid/ready handshake and drives the PLL dynamic phase pins with
// correctly timed rotate and load pulses. Tracks the phase position of
// OUT0/OUT2/OUT3 and aborts any in-flight operation when lock is lost.
//
// Ports:
//   SYS_CLK, RESET_N        clock, asynchronous active-low reset
//   PLL_LOCK                raw PLL lock (asynchronous, synchronized here)
//   REQ_VALID/REQ_READY     request handshake
//   REQ_LOAD                reload all phases (other fields ignored)
//   REQ_OUTSEL              0=OUT0, 2=OUT2, 3=OUT3 (1 is illegal)
//   REQ_DIR, REQ_STEPS      step direction (1=up) and pulse count
//   DONE, ERR               one-cycle completion / error pulses
//   LOCKED                  filtered, synchronized lock
//   PHASE_OUTx_SEL, PHASE_DIRECTION, PHASE_ROTATE, LOAD_PHASE_N  to PLL
//   POS0, POS2, POS3        tracked phase positions
module ccc_phase_step_ctrl #(
    parameter int PHASE_STEPS = 8,
    parameter int ROT_HIGH    = 2,
    parameter int ROT_GAP     = 4,
    parameter int LOCK_FILTER = 16
) (
    input  logic                           SYS_CLK,
    input  logic                           RESET_N,
    input  logic                           PLL_LOCK,
    input  logic                           REQ_VALID,
    output logic                           REQ_READY,
    input  logic                           REQ_LOAD,
    input  logic [1:0]                     REQ_OUTSEL,
    input  logic                           REQ_DIR,
    input  logic [7:0]                     REQ_STEPS,
    output logic                           DONE,
    output logic                           ERR,
    output logic                           LOCKED,
    output logic                           PHASE_OUT0_SEL,
    output logic                           PHASE_OUT2_SEL,
    output logic                           PHASE_OUT3_SEL,
    output logic                           PHASE_DIRECTION,
    output logic                           PHASE_ROTATE,
    output logic                           LOAD_PHASE_N,
    output logic [$clog2(PHASE_STEPS)-1:0] POS0,
    output logic [$clog2(PHASE_STEPS)-1:0] POS2,
    output logic [$clog2(PHASE_STEPS)-1:0] POS3
);

    localparam int PW  = $clog2(PHASE_STEPS);
    localparam int LCW = $clog2(LOCK_FILTER + 1);
    localparam int TMAX = (ROT_HIGH > ROT_GAP) ? ROT_HIGH : ROT_GAP;
    localparam int TW  = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ROT_HI,
        S_ROT_GAP,
        S_LD_LO,
        S_LD_GAP,
        S_FIN
    } state_t;

    // ---------------------------------------------------------------
    // Lock qualification: 2-flop synchronizer plus saturating filter
    // ---------------------------------------------------------------
    logic           r_lock_m;
    logic           r_lock_s;
    logic [LCW-1:0] r_lock_cnt;
    logic           w_locked;

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_lock_m   <= 1'b0;
            r_lock_s   <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_lock_m <= PLL_LOCK;
            r_lock_s <= r_lock_m;
            if (!r_lock_s)
                r_lock_cnt <= '0;
            else if (r_lock_cnt != LCW'(LOCK_FILTER))
                r_lock_cnt <= r_lock_cnt + 1'b1;
        end
    end

    assign w_locked = (r_lock_cnt == LCW'(LOCK_FILTER));

    // ---------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_steps;
    logic [1:0]    r_outsel;
    logic          r_dir;
    logic          r_sel0;
    logic          r_sel2;
    logic          r_sel3;
    logic          r_pdir;
    logic          r_rot;
    logic          r_load_n;
    logic          r_done;
    logic          r_err;
    logic [PW-1:0] r_pos0;
    logic [PW-1:0] r_pos2;
    logic [PW-1:0] r_pos3;

    logic w_accept;
    logic w_abort;

    assign REQ_READY = (r_state == S_IDLE) && w_locked;
    assign w_accept  = REQ_VALID && REQ_READY;
    // FIN has already committed its DONE, so lock loss there is not an abort.
    assign w_abort   = !w_locked && (r_state != S_IDLE) && (r_state != S_FIN);

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_steps  <= '0;
            r_outsel <= '0;
            r_dir    <= 1'b0;
            r_sel0   <= 1'b0;
            r_sel2   <= 1'b0;
            r_sel3   <= 1'b0;
            r_pdir   <= 1'b0;
            r_rot    <= 1'b0;
            r_load_n <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_pos0   <= '0;
            r_pos2   <= '0;
            r_pos3   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_abort) begin
                // Abort wins over a same-cycle pulse completion, so a
                // rotate that was cut short is not counted.
                r_state  <= S_IDLE;
                r_rot    <= 1'b0;
                r_load_n <= 1'b1;
                r_sel0   <= 1'b0;
                r_sel2   <= 1'b0;
                r_sel3   <= 1'b0;
                r_pdir   <= 1'b0;
                r_err    <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_outsel <= REQ_OUTSEL;
                            r_dir    <= REQ_DIR;
                            r_steps  <= REQ_STEPS;
                            if (REQ_LOAD) begin
                                r_state  <= S_LD_LO;
                                r_load_n <= 1'b0;
                                r_timer  <= TW'(ROT_HIGH - 1);
                            end else if (REQ_OUTSEL == 2'd1) begin
                                r_err <= 1'b1;
                            end else if (REQ_STEPS == 8'd0) begin
                                r_state <= S_FIN;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_SETUP;
                                r_sel0  <= (REQ_OUTSEL == 2'd0);
                                r_sel2  <= (REQ_OUTSEL == 2'd2);
                                r_sel3  <= (REQ_OUTSEL == 2'd3);
                                r_pdir  <= REQ_DIR;
                            end
                        end
                    end
                    S_SETUP: begin
                        r_state <= S_ROT_HI;
                        r_rot   <= 1'b1;
                        r_timer <= TW'(ROT_HIGH - 1);
                    end
                    S_ROT_HI: begin
                        if (r_timer == '0) begin
                            r_state <= S_ROT_GAP;
                            r_rot   <= 1'b0;
                            r_timer <= TW'(ROT_GAP - 1);
                            r_steps <= r_steps - 1'b1;
                            // Power-of-two width gives the modulo wrap for free.
                            case (r_outsel)
                                2'd0:    r_pos0 <= r_dir ? r_pos0 + 1'b1 : r_pos0 - 1'b1;
                                2'd2:    r_pos2 <= r_dir ? r_pos2 + 1'b1 : r_pos2 - 1'b1;
                                2'd3:    r_pos3 <= r_dir ? r_pos3 + 1'b1 : r_pos3 - 1'b1;
                                default: ;
                            endcase
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    S_ROT_GAP: begin
                        if (r_timer == '0) begin
                            if (r_steps != 8'd0) begin
                                r_state <= S_ROT_HI;
                                r_rot   <= 1'b1;
                                r_timer <= TW'(ROT_HIGH - 1);
                            end else begin
                                r_state <= S_FIN;
                                r_done  <= 1'b1;
                                r_sel0  <= 1'b0;
                                r_sel2  <= 1'b0;
                                r_sel3  <= 1'b0;
                                r_pdir  <= 1'b0;
                            end
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    S_LD_LO: begin
                        if (r_timer == '0) begin
                            r_state  <= S_LD_GAP;
                            r_load_n <= 1'b1;
                            r_timer  <= TW'(ROT_GAP - 1);
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    S_LD_GAP: begin
                        if (r_timer == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_pos0  <= '0;
                            r_pos2  <= '0;
                            r_pos3  <= '0;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    S_FIN: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign DONE            = r_done;
    assign ERR             = r_err;
    assign LOCKED          = w_locked;
    assign PHASE_OUT0_SEL  = r_sel0;
    assign PHASE_OUT2_SEL  = r_sel2;
    assign PHASE_OUT3_SEL  = r_sel3;
    assign PHASE_DIRECTION = r_pdir;
    assign PHASE_ROTATE    = r_rot;
    assign LOAD_PHASE_N    = r_load_n;
    assign POS0            = r_pos0;
    assign POS2            = r_pos2;
    assign POS3            = r_pos3;

endmodule
